mux_input_conditioner: RTL and testbench

//   Upstream stage of the 4:1 two-bit selector on the NVBoard. Conditions raw

---
 rtl/mux_input_conditioner.sv | 125 ++++++++++++
 tb/tb_mux_input_conditioner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux_input_conditioner.sv
// rtl/mux_input_conditioner.sv - sync, debounce and mode/scan select for the 4:1 two-bit selector
module mux_input_conditioner #(
    parameter int W         = 2,
    parameter int DB_CYCLES = 16,
    parameter int SCAN_DIV  = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_x0,
    input  logic [W-1:0] sw_x1,
    input  logic [W-1:0] sw_x2,
    input  logic [W-1:0] sw_x3,
    input  logic [1:0]   sw_sel,
    input  logic         btn_mode,
    output logic [W-1:0] x0,
    output logic [W-1:0] x1,
    output logic [W-1:0] x2,
    output logic [W-1:0] x3,
    output logic [1:0]   y,
    output logic         scan_mode,
    output logic         upd
);

    localparam int N  = 4 * W + 3;
    localparam int CW = $clog2(DB_CYCLES);
    localparam int DW = $clog2(SCAN_DIV);

    localparam logic [0:0] MANUAL = 1'b0;
    localparam logic [0:0] SCAN   = 1'b1;

    logic [N-1:0]  raw;
    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  deb;
    logic [CW-1:0] cnt [N];

    logic [1:0]    deb_sel;
    logic          deb_btn;
    logic          deb_d;
    logic          press;
    logic [0:0]    state;
    logic [DW-1:0] div;
    logic [4*W+1:0] prev;

    // All raw inputs are treated as one flat bit vector for sync and debounce.
    assign raw = {btn_mode, sw_sel, sw_x3, sw_x2, sw_x1, sw_x0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < N; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign x0      = deb[W-1:0];
    assign x1      = deb[2*W-1:W];
    assign x2      = deb[3*W-1:2*W];
    assign x3      = deb[4*W-1:3*W];
    assign deb_sel = deb[4*W+1:4*W];
    assign deb_btn = deb[4*W+2];
    assign press   = deb_btn & ~deb_d;

    // A press always takes priority over a divider wrap, so y never steps on a mode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MANUAL;
            deb_d <= 1'b0;
            div   <= '0;
            y     <= 2'd0;
        end else begin
            deb_d <= deb_btn;
            case (state)
                MANUAL: begin
                    if (press) begin
                        state <= SCAN;
                        div   <= '0;
                    end else begin
                        y <= deb_sel;
                    end
                end
                default: begin
                    if (press) begin
                        state <= MANUAL;
                        div   <= '0;
                    end else if (div == DW'(SCAN_DIV - 1)) begin
                        div <= '0;
                        y   <= y + 2'd1;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
            endcase
        end
    end

    assign scan_mode = state[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            upd  <= 1'b0;
        end else begin
            prev <= {x3, x2, x1, x0, y};
            upd  <= ({x3, x2, x1, x0, y} != prev);
        end
    end

endmodule

// File: tb/tb_mux_input_conditioner.sv
// tb/tb_mux_input_conditioner.sv - directed vector bench for mux_input_conditioner
module tb_mux_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw_x0, sw_x1, sw_x2, sw_x3, sw_sel;
    logic       btn_mode;
    logic [1:0] x0, x1, x2, x3, y;
    logic       scan_mode, upd;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int toggles = 0;
    logic last_scan = 1'b0;
    logic found;

    typedef struct {
        logic [1:0] a0, a1, a2, a3, sel;
        logic [1:0] e0, e1, e2, e3, ey;
        int         eupd;
    } vec_t;
    vec_t tv [5];

    mux_input_conditioner #(.W(2), .DB_CYCLES(4), .SCAN_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_x0(sw_x0), .sw_x1(sw_x1), .sw_x2(sw_x2), .sw_x3(sw_x3),
        .sw_sel(sw_sel), .btn_mode(btn_mode),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .y(y),
        .scan_mode(scan_mode), .upd(upd)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (upd === 1'b1) upd_cnt++;
            if (scan_mode !== last_scan) toggles++;
            last_scan = scan_mode;
        end
    endtask

    initial begin
        tv[0] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2};
        tv[1] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 0};
        tv[2] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 1};
        tv[3] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 1};
        tv[4] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 1};

        sw_x0 = 0; sw_x1 = 0; sw_x2 = 0; sw_x3 = 0; sw_sel = 0; btn_mode = 0;
        repeat (3) @(negedge clk);
        check("reset_x", {x3, x2, x1, x0}, 0);
        check("reset_y", y, 0);
        check("reset_scan", scan_mode, 0);
        check("reset_upd", upd, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Steady data word: accepted on the 6th edge, single upd pulse
        sw_x2 = 2'b10;
        upd_cnt = 0;
        run(5);
        check("x2_edge5", x2, 0);
        run(1);
        check("x2_edge6", x2, 2);
        run(6);
        check("x2_upd_count", upd_cnt, 1);
        check("x2_others", {x3, x1, x0, y, 1'b0, scan_mode}, 0);

        // Two-cycle glitch on sw_sel is rejected
        sw_sel = 2'd3;
        upd_cnt = 0;
        run(2);
        sw_sel = 2'd0;
        run(12);
        check("glitch_y", y, 0);
        check("glitch_upd", upd_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            sw_x0 = tv[i].a0; sw_x1 = tv[i].a1; sw_x2 = tv[i].a2; sw_x3 = tv[i].a3;
            sw_sel = tv[i].sel;
            upd_cnt = 0;
            run(12);
            check($sformatf("vec%0d_x0", i), x0, tv[i].e0);
            check($sformatf("vec%0d_x1", i), x1, tv[i].e1);
            check($sformatf("vec%0d_x2", i), x2, tv[i].e2);
            check($sformatf("vec%0d_x3", i), x3, tv[i].e3);
            check($sformatf("vec%0d_y", i), y, tv[i].ey);
            check($sformatf("vec%0d_upd", i), upd_cnt, tv[i].eupd);
        end

        // Enter SCAN from y=2, step, then press on a divider wrap edge
        btn_mode = 1'b1;
        for (int n = 1; n <= 56; n++) begin
            run(1);
            if (n == 8) upd_cnt = 0;
            if (n == 46) upd_cnt = 0;
            case (n)
                6:  check("scan_edge6", scan_mode, 0);
                7:  begin check("scan_edge7", scan_mode, 1); check("y_enter", y, 2); end
                10: btn_mode = 1'b0;
                14: check("y_n14", y, 2);
                15: check("y_n15", y, 3);
                22: check("y_n22", y, 3);
                23: check("y_n23", y, 0);
                31: check("y_n31", y, 1);
                32: begin check("scan_upd_count", upd_cnt, 3); sw_sel = 2'd1; end
                39: check("y_n39", y, 2);
                40: btn_mode = 1'b1;
                46: begin check("pre_exit_scan", scan_mode, 1); check("pre_exit_y", y, 2); end
                47: begin check("exit_scan", scan_mode, 0); check("exit_no_step", y, 2); end
                48: check("exit_y_sel", y, 1);
                50: btn_mode = 1'b0;
                56: check("exit_upd_count", upd_cnt, 1);
                default: ;
            endcase
        end

        // Reach SCAN with y=3, then reset mid-debounce
        btn_mode = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            run(1);
            if (k == 8) btn_mode = 1'b0;
            if (scan_mode === 1'b1 && y === 2'd3) found = 1'b1;
        end
        check("reach_y3", found, 1);
        sw_x0 = 2'd2;
        run(4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_y", y, 0);
        check("async_rst_scan", scan_mode, 0);
        check("async_rst_x", {x3, x2, x1, x0}, 0);
        check("async_rst_upd", upd, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_scan = scan_mode;
        run(5);
        check("post_rst_x0_e5", x0, 0);
        run(1);
        check("post_rst_x0_e6", x0, 2);
        check("post_rst_x3", x3, 1);
        run(2);
        check("post_rst_y", y, 1);

        // Long hold toggles once; short bounce after release does nothing
        toggles = 0;
        last_scan = scan_mode;
        btn_mode = 1'b1;
        run(20);
        btn_mode = 1'b0;
        run(10);
        btn_mode = 1'b1;
        run(3);
        btn_mode = 1'b0;
        run(20);
        check("hold_toggles", toggles, 1);
        check("hold_scan", scan_mode, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
